// File: rtl/imem_boot_ctrl.sv
// imem_boot_ctrl
// Boot and arbitration controller for the instruction memory. It streams a
// program from a host loader into the memory, optionally zero-fills the
// unused tail (NOP), then hands the memory read port to the CPU fetch stage.
// The CPU is held in reset whenever it is not running.
//
// Optional feature macro: IMEM_CLEAR_EN (enables the CLEAR tail-fill state).
//
// Ports:
//   clk, reset         : clock, synchronous active-high reset
//   load_req, run_req  : single-cycle command pulses (load wins if both)
//   ld_valid/ld_data/ld_last/ld_ready : loader word stream handshake
//   mem_we/mem_addr/mem_wdata/mem_rdata : instruction memory port
//   cpu_pc/cpu_halt/cpu_instr/cpu_rst   : CPU fetch interface and reset
//   prog_len           : words written by the last load (1..2^ADDR_W)
//   done               : sticky, set when the CPU retires HALT
module imem_boot_ctrl #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_req,
  input  logic              run_req,
  input  logic              ld_valid,
  input  logic [DATA_W-1:0] ld_data,
  input  logic              ld_last,
  output logic              ld_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic [ADDR_W-1:0] cpu_pc,
  input  logic              cpu_halt,
  output logic [DATA_W-1:0] cpu_instr,
  output logic              cpu_rst,
  output logic [ADDR_W:0]   prog_len,
  output logic              done
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    CLEAR  = 3'd2,
    RUN    = 3'd3,
    HALTED = 3'd4
  } state_t;

  localparam logic [ADDR_W-1:0] ADDR_MAX = {ADDR_W{1'b1}};
  localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W:0]   LEN_MAX  = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0]   LEN_ONE  = {{ADDR_W{1'b0}}, 1'b1};

  state_t            state_r, state_s;
  logic [ADDR_W-1:0] waddr_r, waddr_s;
  logic [ADDR_W:0]   prog_len_s;
  logic              done_s;

  // Next-state, datapath updates and combinational memory/CPU port decode
  always_comb begin
    state_s    = state_r;
    waddr_s    = waddr_r;
    prog_len_s = prog_len;
    done_s     = done;
    ld_ready   = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = waddr_r;
    mem_wdata  = {DATA_W{1'b0}};
    cpu_instr  = {DATA_W{1'b0}};

    case (state_r)
      IDLE: begin
        if (load_req) begin
          state_s    = LOAD;
          waddr_s    = {ADDR_W{1'b0}};
          prog_len_s = {(ADDR_W+1){1'b0}};
        end else if (run_req) begin
          state_s = RUN;
        end else begin
          state_s = IDLE;
        end
      end

      LOAD: begin
        ld_ready = 1'b1;
        if (ld_valid) begin
          mem_we    = 1'b1;
          mem_wdata = ld_data;
          waddr_s   = waddr_r + ADDR_ONE;
          if (prog_len == LEN_MAX) begin
            prog_len_s = prog_len;
          end else begin
            prog_len_s = prog_len + LEN_ONE;
          end
          // Writing the top address implies the last beat, so waddr only
          // wraps to 0 on an exit.
          if (ld_last || (waddr_r == ADDR_MAX)) begin
`ifdef IMEM_CLEAR_EN
            if (waddr_r != ADDR_MAX) begin
              state_s = CLEAR;
            end else begin
              state_s = RUN;
            end
`else
            state_s = RUN;
`endif
          end else begin
            state_s = LOAD;
          end
        end else begin
          state_s = LOAD;
        end
      end

      CLEAR: begin
        mem_we  = 1'b1;
        waddr_s = waddr_r + ADDR_ONE;
        if (waddr_r == ADDR_MAX) begin
          state_s = RUN;
        end else begin
          state_s = CLEAR;
        end
      end

      RUN: begin
        mem_addr  = cpu_pc;
        cpu_instr = mem_rdata;
        if (cpu_halt) begin
          state_s = HALTED;
          done_s  = 1'b1;
        end else begin
          state_s = RUN;
        end
      end

      HALTED: begin
        if (load_req) begin
          state_s    = LOAD;
          waddr_s    = {ADDR_W{1'b0}};
          prog_len_s = {(ADDR_W+1){1'b0}};
          done_s     = 1'b0;
        end else if (run_req) begin
          // CPU restarts from PC 0 because it leaves reset.
          state_s = RUN;
          done_s  = 1'b0;
        end else begin
          state_s = HALTED;
        end
      end

      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State and registered outputs; cpu_rst follows the next state so it is
  // low exactly during RUN cycles.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r  <= IDLE;
      waddr_r  <= {ADDR_W{1'b0}};
      prog_len <= {(ADDR_W+1){1'b0}};
      done     <= 1'b0;
      cpu_rst  <= 1'b1;
    end else begin
      state_r  <= state_s;
      waddr_r  <= waddr_s;
      prog_len <= prog_len_s;
      done     <= done_s;
      cpu_rst  <= (state_s != RUN);
    end
  end

endmodule

// File: tb/tb_imem_boot_ctrl.sv
// Testbench for imem_boot_ctrl: scoreboard of expected memory writes, a
// behavioural 256x16 memory, and per-scenario tasks.
module tb_imem_boot_ctrl;

  logic        clk;
  logic        reset;
  logic        load_req;
  logic        run_req;
  logic        ld_valid;
  logic [15:0] ld_data;
  logic        ld_last;
  logic        ld_ready;
  logic        mem_we;
  logic [7:0]  mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic [7:0]  cpu_pc;
  logic        cpu_halt;
  logic [15:0] cpu_instr;
  logic        cpu_rst;
  logic [8:0]  prog_len;
  logic        done;

  int checks = 0;
  int errors = 0;

  logic [23:0] exp_q[$];
  logic [15:0] mem[256];
  logic [15:0] prog[256];
  logic        fill;

  imem_boot_ctrl #(.ADDR_W(8), .DATA_W(16)) dut (
    .clk(clk), .reset(reset), .load_req(load_req), .run_req(run_req),
    .ld_valid(ld_valid), .ld_data(ld_data), .ld_last(ld_last),
    .ld_ready(ld_ready), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .cpu_pc(cpu_pc),
    .cpu_halt(cpu_halt), .cpu_instr(cpu_instr), .cpu_rst(cpu_rst),
    .prog_len(prog_len), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural memory: fill with a stale pattern, otherwise write on mem_we.
  always @(posedge clk) begin
    if (fill) begin
      for (int i = 0; i < 256; i++) mem[i] <= 16'hDEAD;
    end else if (mem_we) begin
      mem[mem_addr] <= mem_wdata;
    end
  end
  assign mem_rdata = mem[mem_addr];

  // Write monitor: each observed write must match the head of the scoreboard.
  always @(negedge clk) begin
    logic [23:0] e;
    if (mem_we === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write addr=%0h data=%0h", mem_addr, mem_wdata);
      end else begin
        e = exp_q.pop_front();
        if ({mem_addr, mem_wdata} !== e) begin
          errors++;
          $display("FAIL write got addr=%0h data=%0h want addr=%0h data=%0h",
                   mem_addr, mem_wdata, e[23:16], e[15:0]);
        end
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic start_load;
    load_req = 1'b1;
    #1;
    tick();
    load_req = 1'b0;
  endtask

  // Stream n words from prog[]; optional 5-cycle stall before word stall_at.
  task automatic load_words(input int n, input bit use_last, input int stall_at);
    for (int i = 0; i < n; i++) begin
      if (i == stall_at) begin
        for (int s = 0; s < 5; s++) begin
          ld_valid = 1'b0;
          ld_last  = 1'b0;
          #1;
          checks++;
          if (mem_we !== 1'b0 || ld_ready !== 1'b1 || mem_addr !== i[7:0]) begin
            errors++;
            $display("FAIL stall we=%b ready=%b addr=%0h want we=0 ready=1 addr=%0h",
                     mem_we, ld_ready, mem_addr, i[7:0]);
          end
          tick();
        end
      end
      ld_valid = 1'b1;
      ld_data  = prog[i];
      ld_last  = use_last && (i == n - 1);
      exp_q.push_back({i[7:0], prog[i]});
      #1;
      checks++;
      if (ld_ready !== 1'b1) begin
        errors++;
        $display("FAIL ld_ready beat %0d got %b want 1", i, ld_ready);
      end
      tick();
    end
    ld_valid = 1'b0;
    ld_last  = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    fill  = 1'b1;
    repeat (2) tick();
    checks++;
    if (cpu_rst !== 1'b1 || ld_ready !== 1'b0 || mem_we !== 1'b0 || done !== 1'b0 ||
        prog_len !== 9'd0 || mem_addr !== 8'd0 || cpu_instr !== 16'd0) begin
      errors++;
      $display("FAIL reset rst=%b ready=%b we=%b done=%b len=%0d addr=%0h instr=%0h want 1 0 0 0 0 0 0",
               cpu_rst, ld_ready, mem_we, done, prog_len, mem_addr, cpu_instr);
    end
    reset = 1'b0;
    fill  = 1'b0;
  endtask

  task automatic test_load24;
    int cyc;
    for (int i = 0; i < 24; i++) prog[i] = 16'(32'h1101 + i * 32'h0101);
    prog[23] = 16'h0800;
    start_load();
    checks++;
    if (ld_ready !== 1'b1 || cpu_rst !== 1'b1) begin
      errors++;
      $display("FAIL load_entry ready=%b rst=%b want 1 1", ld_ready, cpu_rst);
    end
    load_words(24, 1'b1, 10);
    checks++;
    if (prog_len !== 9'd24) begin
      errors++;
      $display("FAIL prog_len24 got %0d want 24", prog_len);
    end
`ifdef IMEM_CLEAR_EN
    for (int a = 24; a < 256; a++) exp_q.push_back({a[7:0], 16'h0000});
    cyc = 0;
    while (cpu_rst !== 1'b0 && cyc < 300) begin
      tick();
      cyc++;
    end
    checks++;
    if (cyc != 232) begin
      errors++;
      $display("FAIL clear_len got %0d cycles want 232", cyc);
    end
`else
    cyc = 0;
    checks++;
    if (cpu_rst !== 1'b0 || ld_ready !== 1'b0) begin
      errors++;
      $display("FAIL run_entry rst=%b ready=%b want 0 0 (cyc %0d)", cpu_rst, ld_ready, cyc);
    end
`endif
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL load24_pending got %0d want 0", exp_q.size());
    end
  endtask

  task automatic test_run_halt;
    cpu_pc = 8'd5;
    #1;
    checks++;
    if (mem_addr !== 8'd5 || cpu_instr !== prog[5] || mem_we !== 1'b0) begin
      errors++;
      $display("FAIL run_fetch addr=%0h instr=%0h we=%b want 5 %0h 0",
               mem_addr, cpu_instr, mem_we, prog[5]);
    end
    cpu_pc = 8'd30;
    #1;
    checks++;
`ifdef IMEM_CLEAR_EN
    if (cpu_instr !== 16'h0000) begin
      errors++;
      $display("FAIL tail got %0h want 0000", cpu_instr);
    end
`else
    if (cpu_instr !== 16'hDEAD) begin
      errors++;
      $display("FAIL tail got %0h want dead", cpu_instr);
    end
`endif
    cpu_halt = 1'b1;
    tick();
    cpu_halt = 1'b0;
    #1;
    checks++;
    if (done !== 1'b1 || cpu_rst !== 1'b1 || cpu_instr !== 16'd0) begin
      errors++;
      $display("FAIL halt done=%b rst=%b instr=%0h want 1 1 0", done, cpu_rst, cpu_instr);
    end
    run_req = 1'b1;
    tick();
    run_req = 1'b0;
    checks++;
    if (done !== 1'b0 || cpu_rst !== 1'b0) begin
      errors++;
      $display("FAIL rerun done=%b rst=%b want 0 0", done, cpu_rst);
    end
    cpu_pc = 8'd0;
  endtask

  task automatic test_priority;
    load_req = 1'b1;
    tick();
    load_req = 1'b0;
    #1;
    checks++;
    if (cpu_rst !== 1'b0 || ld_ready !== 1'b0 || prog_len !== 9'd24) begin
      errors++;
      $display("FAIL run_ignore rst=%b ready=%b len=%0d want 0 0 24", cpu_rst, ld_ready, prog_len);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    load_req = 1'b1;
    run_req  = 1'b1;
    tick();
    load_req = 1'b0;
    run_req  = 1'b0;
    #1;
    checks++;
    if (ld_ready !== 1'b1 || cpu_rst !== 1'b1) begin
      errors++;
      $display("FAIL priority ready=%b rst=%b want 1 1", ld_ready, cpu_rst);
    end
    load_words(3, 1'b0, -1);
    checks++;
    if (prog_len !== 9'd3) begin
      errors++;
      $display("FAIL partial_len got %0d want 3", prog_len);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    checks++;
    if (ld_ready !== 1'b0 || cpu_rst !== 1'b1 || prog_len !== 9'd0) begin
      errors++;
      $display("FAIL abort ready=%b rst=%b len=%0d want 0 1 0", ld_ready, cpu_rst, prog_len);
    end
  endtask

  task automatic test_full_depth;
    for (int i = 0; i < 256; i++) prog[i] = 16'(i * 7 + 32'h4000);
    start_load();
    load_words(255, 1'b0, -1);
    checks++;
    if (prog_len !== 9'd255 || ld_ready !== 1'b1) begin
      errors++;
      $display("FAIL full_pre len=%0d ready=%b want 255 1", prog_len, ld_ready);
    end
    ld_valid = 1'b1;
    ld_data  = prog[255];
    ld_last  = 1'b0;
    exp_q.push_back({8'hFF, prog[255]});
    tick();
    ld_valid = 1'b0;
    #1;
    checks++;
    if (prog_len !== 9'd256 || cpu_rst !== 1'b0 || ld_ready !== 1'b0 || mem_we !== 1'b0) begin
      errors++;
      $display("FAIL full_exit len=%0d rst=%b ready=%b we=%b want 256 0 0 0",
               prog_len, cpu_rst, ld_ready, mem_we);
    end
    cpu_pc = 8'd255;
    #1;
    checks++;
    if (cpu_instr !== prog[255]) begin
      errors++;
      $display("FAIL full_fetch got %0h want %0h", cpu_instr, prog[255]);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL full_pending got %0d want 0", exp_q.size());
    end
  endtask

  initial begin
    reset    = 1'b1;
    fill     = 1'b1;
    load_req = 1'b0;
    run_req  = 1'b0;
    ld_valid = 1'b0;
    ld_data  = 16'd0;
    ld_last  = 1'b0;
    cpu_pc   = 8'd0;
    cpu_halt = 1'b0;
    test_reset();
    test_load24();
    test_run_halt();
    test_priority();
    test_full_depth();
    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
